alu_ablaufsteuerung: RTL

ALU_ABLAUFSTEUERUNG -- requirements
Module: alu_ablaufsteuerung

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_befehlsdekoder.sv | 44 ++++
 rtl/alu_ablaufsteuerung.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU sequencer:
//   - function-code constants of the ALU operations that matter to sequencing
//   - controller state encoding (zustand_t)
//   - latency class of an instruction (klasse_t)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [5:0] FC_ADD  = 6'b000000;
   localparam logic [5:0] FC_SUB  = 6'b000001;
   localparam logic [5:0] FC_MUL  = 6'b000010;
   localparam logic [5:0] FC_SQRT = 6'b000011;
   localparam logic [5:0] FC_DIV  = 6'b000100;
   localparam logic [5:0] FC_MOD  = 6'b000101;

   typedef enum logic [2:0] {
      LEERLAUF  = 3'd0,
      START     = 3'd1,
      WARTEN    = 3'd2,
      SCHREIBEN = 3'd3,
      ERFASSEN  = 3'd4,
      AUSGABE   = 3'd5
   } zustand_t;

   // EINFACH: single wait cycle, MUL: MUL_LATENZ wait cycles,
   // VARIABEL: wait for a done flag (bounded by TIMEOUT), ILLEGAL: rejected.
   typedef enum logic [1:0] {
      EINFACH  = 2'd0,
      MUL      = 2'd1,
      VARIABEL = 2'd2,
      ILLEGAL  = 2'd3
   } klasse_t;

endpackage

// File: rtl/alu_befehlsdekoder.sv
// ---------------------------------------------------------------------------
// alu_befehlsdekoder
// Purely combinational map from a 6-bit ALU function code to its latency
// class. Legal codes have bit 5 clear and the low five bits in one of the
// groups 0-9, 16-21 or 24-28; everything else is ILLEGAL.
// Ports:
//   funktionscode  in   6  function code to classify
//   klasse         out  2  latency class (klasse_t encoding)
// ---------------------------------------------------------------------------
module alu_befehlsdekoder
   import alu_pkg::*;
(
   input  logic [5:0] funktionscode,
   output logic [1:0] klasse
);

   logic [4:0] code_low;
   klasse_t    klasse_int;

   assign code_low = funktionscode[4:0];

   // NOTE: every signal written in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      klasse_int = ILLEGAL;
      if (funktionscode[5] == 1'b0) begin
         if ((code_low <= 5'd9) ||
             ((code_low >= 5'd16) && (code_low <= 5'd21)) ||
             ((code_low >= 5'd24) && (code_low <= 5'd28))) begin
            klasse_int = EINFACH;
         end
         if (funktionscode == FC_MUL) begin
            klasse_int = MUL;
         end
         if ((funktionscode == FC_SQRT) || (funktionscode == FC_DIV) ||
             (funktionscode == FC_MOD)) begin
            klasse_int = VARIABEL;
         end
      end
   end

   assign klasse = klasse_int;

endmodule

// File: rtl/alu_ablaufsteuerung.sv
// ---------------------------------------------------------------------------
// alu_ablaufsteuerung
// Sequencer between an instruction source and a multi-cycle ALU. Accepts one
// instruction at a time, registers operands/code/tag, pulses ALU_Start, waits
// a class-dependent number of cycles (fixed for simple ops and Mul, done-flag
// driven with timeout for Div/Mod/SQRT), pulses ALU_Schreiben, captures the
// ALU result and holds it until the consumer takes it. Illegal codes and
// timeouts produce Ergebnis=0 with Ergebnis_Fehler=1.
// Ports:
//   Clock, Reset                 clock, async active-low reset
//   Befehl_*                     instruction handshake and payload
//   ALU_Daten1/2, ALU_Funktionscode, ALU_Start, ALU_Schreiben  to the ALU
//   ALU_Ergebnis, Division_Fertig, Wurzel_Fertig               from the ALU
//   Ergebnis_Gueltig/Bereit      result handshake
//   Ergebnis, Ergebnis_Zielregister, Ergebnis_Fehler           result payload
// ---------------------------------------------------------------------------
module alu_ablaufsteuerung
   import alu_pkg::*;
#(
   parameter int BREITE     = 32,
   parameter int MUL_LATENZ = 2,   // must be >= 1
   parameter int TIMEOUT    = 64   // must be >= 1
)
(
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Befehl_Gueltig,
   output logic              Befehl_Bereit,
   input  logic [5:0]        Befehl_Funktionscode,
   input  logic [BREITE-1:0] Befehl_Daten1,
   input  logic [BREITE-1:0] Befehl_Daten2,
   input  logic [4:0]        Befehl_Zielregister,
   output logic [BREITE-1:0] ALU_Daten1,
   output logic [BREITE-1:0] ALU_Daten2,
   output logic [5:0]        ALU_Funktionscode,
   output logic              ALU_Start,
   output logic              ALU_Schreiben,
   input  logic [BREITE-1:0] ALU_Ergebnis,
   input  logic              Division_Fertig,
   input  logic              Wurzel_Fertig,
   output logic              Ergebnis_Gueltig,
   input  logic              Ergebnis_Bereit,
   output logic [BREITE-1:0] Ergebnis,
   output logic [4:0]        Ergebnis_Zielregister,
   output logic              Ergebnis_Fehler
);

   localparam int ZMAX = (TIMEOUT > MUL_LATENZ) ? TIMEOUT : MUL_LATENZ;
   localparam int ZW   = $clog2(ZMAX + 1);

   localparam logic [ZW-1:0] Z_EINS  = ZW'(1);
   localparam logic [ZW-1:0] Z_MUL   = ZW'(MUL_LATENZ);
   // Last WARTEN cycle of a variable op is the one where the count,
   // started at 0, equals TIMEOUT-1.
   localparam logic [ZW-1:0] Z_LIMIT = ZW'(TIMEOUT - 1);

   zustand_t      zustand, zustand_next;
   logic [ZW-1:0] zaehler, zaehler_next;
   klasse_t       klasse, dek_klasse;
   logic [1:0]    dek_bits;
   logic          aktiv;          // 0 while in reset, 1 from the first edge after it
   logic          annahme;
   logic          fertig;
   logic          fehler_setzen;

   alu_befehlsdekoder u_dekoder (
      .funktionscode (Befehl_Funktionscode),
      .klasse        (dek_bits)
   );

   assign dek_klasse = klasse_t'(dek_bits);
   assign annahme    = Befehl_Bereit & Befehl_Gueltig;

   // Only the done flag matching the running operation counts.
   assign fertig = (ALU_Funktionscode == FC_SQRT) ? Wurzel_Fertig : Division_Fertig;

   // NOTE: sequential state uses non-blocking assignments and the
   // asynchronous reset sits in the sensitivity list, so Reset=0 acts at once.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         zustand <= LEERLAUF;
         zaehler <= '0;
         aktiv   <= 1'b0;
      end else begin
         zustand <= zustand_next;
         zaehler <= zaehler_next;
         aktiv   <= 1'b1;
      end
   end

   always_comb begin
      zustand_next     = zustand;
      zaehler_next     = zaehler;
      fehler_setzen    = 1'b0;
      Befehl_Bereit    = 1'b0;
      ALU_Start        = 1'b0;
      ALU_Schreiben    = 1'b0;
      Ergebnis_Gueltig = 1'b0;

      case (zustand)
         LEERLAUF: begin
            // aktiv keeps the handshake low during reset itself.
            Befehl_Bereit = aktiv;
            if (aktiv && Befehl_Gueltig) begin
               if (dek_klasse == ILLEGAL) begin
                  zustand_next  = AUSGABE;
                  fehler_setzen = 1'b1;
               end else begin
                  zustand_next = START;
               end
            end
         end

         START: begin
            ALU_Start    = 1'b1;
            zustand_next = WARTEN;
            case (klasse)
               MUL:      zaehler_next = Z_MUL;
               VARIABEL: zaehler_next = '0;
               default:  zaehler_next = Z_EINS;
            endcase
         end

         WARTEN: begin
            if (klasse == VARIABEL) begin
               // A done flag in the final cycle still beats the timeout.
               if (fertig) begin
                  zustand_next = SCHREIBEN;
               end else if (zaehler == Z_LIMIT) begin
                  zustand_next  = AUSGABE;
                  fehler_setzen = 1'b1;
               end else begin
                  zaehler_next = zaehler + Z_EINS;
               end
            end else begin
               if (zaehler <= Z_EINS) begin
                  zustand_next = SCHREIBEN;
               end else begin
                  zaehler_next = zaehler - Z_EINS;
               end
            end
         end

         SCHREIBEN: begin
            ALU_Schreiben = 1'b1;
            zustand_next  = ERFASSEN;
         end

         ERFASSEN: begin
            zustand_next = AUSGABE;
         end

         AUSGABE: begin
            Ergebnis_Gueltig = 1'b1;
            if (Ergebnis_Bereit) begin
               zustand_next = LEERLAUF;
            end
         end

         default: begin
            zustand_next = LEERLAUF;
         end
      endcase
   end

   // Datapath registers: operands/code/tag are only loaded on acceptance, so
   // they stay constant for the whole operation.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         ALU_Daten1            <= '0;
         ALU_Daten2            <= '0;
         ALU_Funktionscode     <= '0;
         klasse                <= EINFACH;
         Ergebnis              <= '0;
         Ergebnis_Zielregister <= '0;
         Ergebnis_Fehler       <= 1'b0;
      end else begin
         if (annahme) begin
            ALU_Daten1            <= Befehl_Daten1;
            ALU_Daten2            <= Befehl_Daten2;
            ALU_Funktionscode     <= Befehl_Funktionscode;
            klasse                <= dek_klasse;
            Ergebnis_Zielregister <= Befehl_Zielregister;
         end
         if (zustand == ERFASSEN) begin
            Ergebnis        <= ALU_Ergebnis;
            Ergebnis_Fehler <= 1'b0;
         end else if (fehler_setzen) begin
            Ergebnis        <= '0;
            Ergebnis_Fehler <= 1'b1;
         end
      end
   end

endmodule
